// File: rtl/frame_ram_reader_pkg.sv
// rtl/frame_ram_reader_pkg.sv - shared camera frame geometry and pixel tag types
package frame_ram_reader_pkg;

  // Geometry shared by the capture writer and the frame reader
  localparam int CAM_IMG_WIDTH    = 160;
  localparam int CAM_IMG_HEIGHT   = 120;
  localparam int CAM_ADDR_W       = 15;
  localparam int CAM_DATA_W       = 8;
  localparam int CAM_FRAME_PIXELS = CAM_IMG_WIDTH * CAM_IMG_HEIGHT;

  // Framing markers that travel alongside each pixel
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_tag_t;

  localparam int TAG_W = $bits(pix_tag_t);

  // Counter width for a range of n values, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_ram_reader_if.sv
// rtl/frame_ram_reader_if.sv - RAM read port and pixel stream bundle
interface frame_ram_reader_if #(
  parameter int ADDR_W = frame_ram_reader_pkg::CAM_ADDR_W,
  parameter int DATA_W = frame_ram_reader_pkg::CAM_DATA_W
) ();

  logic [DATA_W-1:0] i_RAM_Data;
  logic [ADDR_W-1:0] o_RAM_Adress;
  logic              o_RAM_Read_Enable;
  logic [DATA_W-1:0] o_Pixel;
  logic              o_Pixel_Valid;
  logic              i_Pixel_Ready;
  logic              o_SOF;
  logic              o_EOL;
  logic              o_EOF;

  // Reader side: drives the RAM address/strobe and the pixel stream
  modport master (
    input  i_RAM_Data, i_Pixel_Ready,
    output o_RAM_Adress, o_RAM_Read_Enable,
    output o_Pixel, o_Pixel_Valid, o_SOF, o_EOL, o_EOF
  );

  // RAM and consumer side
  modport slave (
    output i_RAM_Data, i_Pixel_Ready,
    input  o_RAM_Adress, o_RAM_Read_Enable,
    input  o_Pixel, o_Pixel_Valid, o_SOF, o_EOL, o_EOF
  );

endinterface

// File: rtl/frame_ram_reader_pixel_skid_fifo.sv
// rtl/frame_ram_reader_pixel_skid_fifo.sv - two-entry skid FIFO for tagged pixels
module pixel_skid_fifo
  import frame_ram_reader_pkg::*;
#(
  parameter int WIDTH = CAM_DATA_W + TAG_W
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Push,
  input  logic [WIDTH-1:0] i_Data,
  input  logic             i_Pop,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Full,
  output logic             o_Empty,
  output logic [1:0]       o_Count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  // A pop frees a slot in the same cycle, so a full FIFO may still accept a push
  assign w_pop  = i_Pop && (r_count != 2'd0);
  assign w_push = i_Push && ((r_count != 2'd2) || w_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_Data;
        r_wr_ptr        <= !r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= !r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_Data  = r_mem[r_rd_ptr];
  assign o_Full  = (r_count == 2'd2);
  assign o_Empty = (r_count == 2'd0);
  assign o_Count = r_count;

endmodule

// File: rtl/frame_ram_reader.sv
// rtl/frame_ram_reader.sv - streams one stored frame out of the frame RAM in raster order
module frame_ram_reader
  import frame_ram_reader_pkg::*;
#(
  parameter int IMG_WIDTH  = CAM_IMG_WIDTH,
  parameter int IMG_HEIGHT = CAM_IMG_HEIGHT,
  parameter int ADDR_W     = CAM_ADDR_W,
  parameter int DATA_W     = CAM_DATA_W
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Start,
  output logic               o_Busy,
  output logic               o_Frame_Done,
  frame_ram_reader_if.master bus
);

  localparam int FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int X_W          = cnt_width(IMG_WIDTH);
  localparam int Y_W          = cnt_width(IMG_HEIGHT);
  localparam int ENTRY_W      = DATA_W + TAG_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [X_W-1:0]    LAST_X    = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0]    LAST_Y    = Y_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_last_addr;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic               r_inflight;
  pix_tag_t           r_tag;
  logic               w_issue;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [1:0]         w_count;
  logic [ENTRY_W-1:0] w_head;
  pix_tag_t           w_head_tag;
  logic [2:0]         w_used;
  logic [2:0]         w_limit;
  logic               w_credit;

  // Buffered plus in-flight pixels may never exceed the two FIFO slots; a pop
  // this cycle returns one credit so a streaming consumer sees no bubbles.
  assign w_pop      = !w_empty && bus.i_Pixel_Ready;
  assign w_used     = {1'b0, w_count} + {2'b00, r_inflight};
  assign w_limit    = 3'd2 + {2'b00, w_pop};
  assign w_credit   = (w_used < w_limit) && (!w_full || w_pop);
  assign w_head_tag = w_head[TAG_W-1:0];

  // State register
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, read issue and status outputs
  always_comb begin
    w_next       = r_state;
    w_issue      = 1'b0;
    o_Busy       = 1'b1;
    o_Frame_Done = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_Busy = 1'b0;
        if (i_Start) begin
          w_next = S_READ;
        end
      end
      S_READ: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (r_addr == LAST_ADDR) begin
            w_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_pop && w_head_tag.eof) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_Frame_Done = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Address/raster counters and the tag of the read currently in flight
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_addr      <= '0;
      r_last_addr <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_inflight  <= 1'b0;
      r_tag       <= '0;
    end else begin
      r_inflight <= w_issue;
      if ((r_state == S_IDLE) && i_Start) begin
        r_addr <= '0;
        r_x    <= '0;
        r_y    <= '0;
      end else if (w_issue) begin
        r_last_addr <= r_addr;
        r_tag.sof   <= (r_addr == '0);
        r_tag.eol   <= (r_x == LAST_X);
        r_tag.eof   <= (r_x == LAST_X) && (r_y == LAST_Y);
        if (r_addr != LAST_ADDR) begin
          r_addr <= r_addr + 1'b1;
        end
        if (r_x == LAST_X) begin
          r_x <= '0;
          r_y <= (r_y == LAST_Y) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  pixel_skid_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .i_Clk  (i_Clk),
    .i_Rst_n(i_Rst_n),
    .i_Push (r_inflight),
    .i_Data ({bus.i_RAM_Data, r_tag}),
    .i_Pop  (w_pop),
    .o_Data (w_head),
    .o_Full (w_full),
    .o_Empty(w_empty),
    .o_Count(w_count)
  );

  assign bus.o_RAM_Read_Enable = w_issue;
  assign bus.o_RAM_Adress      = w_issue ? r_addr : r_last_addr;
  assign bus.o_Pixel_Valid     = !w_empty;
  assign bus.o_Pixel           = w_empty ? '0 : w_head[ENTRY_W-1:TAG_W];
  assign bus.o_SOF             = !w_empty && w_head_tag.sof;
  assign bus.o_EOL             = !w_empty && w_head_tag.eol;
  assign bus.o_EOF             = !w_empty && w_head_tag.eof;

endmodule

// File: tb/tb_frame_ram_reader.sv
// tb/tb_frame_ram_reader.sv - self-checking bench for frame_ram_reader
module tb_frame_ram_reader;
  import frame_ram_reader_pkg::*;

  typedef struct packed {
    logic        re;
    logic [14:0] addr;
    logic        valid;
    logic [7:0]  pix;
    logic        sof;
    logic        eol;
    logic        eof;
    logic        busy;
    logic        done;
  } out_t;

  typedef struct {
    int   off;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   = 1'b0;
  logic       start_s = 1'b0;
  logic       ready_s = 1'b1;
  logic       start_b = 1'b0;
  logic       ready_b = 1'b1;
  logic       busy_s, done_s, busy_b, done_b;
  logic [7:0] ram_s = 8'd0;
  logic [7:0] ram_b = 8'd0;
  int         checks = 0;
  int         errors = 0;

  frame_ram_reader_if #(.ADDR_W(15), .DATA_W(8)) bus_s ();
  frame_ram_reader_if #(.ADDR_W(15), .DATA_W(8)) bus_b ();

  frame_ram_reader #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .ADDR_W(15), .DATA_W(8)) dut_s (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start_s),
    .o_Busy(busy_s), .o_Frame_Done(done_s), .bus(bus_s)
  );

  frame_ram_reader dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start_b),
    .o_Busy(busy_b), .o_Frame_Done(done_b), .bus(bus_b)
  );

  // RAM models: one-cycle read latency, contents = address + 1
  always @(posedge clk) begin
    if (bus_s.o_RAM_Read_Enable) ram_s <= bus_s.o_RAM_Adress[7:0] + 8'd1;
    if (bus_b.o_RAM_Read_Enable) ram_b <= bus_b.o_RAM_Adress[7:0] + 8'd1;
  end

  assign bus_s.i_RAM_Data    = ram_s;
  assign bus_s.i_Pixel_Ready = ready_s;
  assign bus_b.i_RAM_Data    = ram_b;
  assign bus_b.i_Pixel_Ready = ready_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic out_t samp_s();
    return {bus_s.o_RAM_Read_Enable, bus_s.o_RAM_Adress, bus_s.o_Pixel_Valid, bus_s.o_Pixel,
            bus_s.o_SOF, bus_s.o_EOL, bus_s.o_EOF, busy_s, done_s};
  endfunction

  function automatic out_t mk(input logic re, input int addr, input logic valid, input int pix,
                              input logic sof, input logic eol, input logic eof,
                              input logic busy, input logic done);
    return {re, 15'(addr), valid, 8'(pix), sof, eol, eof, busy, done};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic t_reset();
    rst_n   = 1'b0;
    start_s = 1'b1;
    start_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_c%0d", i), samp_s(), '0);
    end
    check("reset_big_busy", {busy_b, bus_b.o_RAM_Read_Enable, bus_b.o_Pixel_Valid}, 3'b000);
    next_cycle();
    rst_n   = 1'b1;
    start_s = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic t_table();
    vec_t vt[13];
    vt[0]  = '{off: 0,  exp: mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vt[1]  = '{off: 1,  exp: mk(1, 0, 0, 0, 0, 0, 0, 1, 0)};
    vt[2]  = '{off: 2,  exp: mk(1, 1, 0, 0, 0, 0, 0, 1, 0)};
    vt[3]  = '{off: 3,  exp: mk(1, 2, 1, 1, 1, 0, 0, 1, 0)};
    vt[4]  = '{off: 4,  exp: mk(1, 3, 1, 2, 0, 0, 0, 1, 0)};
    vt[5]  = '{off: 5,  exp: mk(1, 4, 1, 3, 0, 0, 0, 1, 0)};
    vt[6]  = '{off: 6,  exp: mk(1, 5, 1, 4, 0, 1, 0, 1, 0)};
    vt[7]  = '{off: 7,  exp: mk(1, 6, 1, 5, 0, 0, 0, 1, 0)};
    vt[8]  = '{off: 8,  exp: mk(1, 7, 1, 6, 0, 0, 0, 1, 0)};
    vt[9]  = '{off: 9,  exp: mk(0, 7, 1, 7, 0, 0, 0, 1, 0)};
    vt[10] = '{off: 10, exp: mk(0, 7, 1, 8, 0, 1, 1, 1, 0)};
    vt[11] = '{off: 11, exp: mk(0, 7, 0, 0, 0, 0, 0, 1, 1)};
    vt[12] = '{off: 12, exp: mk(0, 7, 0, 0, 0, 0, 0, 0, 0)};
    ready_s = 1'b1;
    next_cycle();
    start_s = 1'b1;
    @(negedge clk);
    check("frame_off0", samp_s(), vt[0].exp);
    for (int i = 1; i < 13; i++) begin
      next_cycle();
      start_s = 1'b0;
      @(negedge clk);
      check($sformatf("frame_off%0d", vt[i].off), samp_s(), vt[i].exp);
    end
  endtask

  task automatic t_backpressure();
    int         nx = 0, hold = 0, issued = 0, max_out = 0;
    bit         post = 0, alt = 1, prev_stall = 0, done_seen = 0;
    out_t       cur, prev;
    logic [7:0] got_pix[$];
    logic [2:0] got_tag[$];
    prev = '0;
    for (int c = 0; c < 80 && !done_seen; c++) begin
      next_cycle();
      start_s = (c == 0);
      if (!post) ready_s = 1'b1;
      else if (hold > 0) begin ready_s = 1'b0; hold--; end
      else begin ready_s = alt; alt = !alt; end
      @(negedge clk);
      cur = samp_s();
      if (prev_stall)
        check($sformatf("bp_stall_hold_c%0d", c), {cur.valid, cur.pix, cur.sof, cur.eol, cur.eof},
              {prev.valid, prev.pix, prev.sof, prev.eol, prev.eof});
      prev_stall = cur.valid && !ready_s;
      prev       = cur;
      if (cur.re) issued++;
      if (cur.valid && ready_s) begin
        got_pix.push_back(cur.pix);
        got_tag.push_back({cur.sof, cur.eol, cur.eof});
        nx++;
        if (nx == 2) begin post = 1; hold = 5; end
      end
      if (issued - nx > max_out) max_out = issued - nx;
      if (cur.done) done_seen = 1;
    end
    ready_s = 1'b1;
    check("bp_done_seen", done_seen, 1);
    check("bp_count", got_pix.size(), 8);
    for (int i = 0; i < got_pix.size() && i < 8; i++) begin
      check($sformatf("bp_pix%0d", i), got_pix[i], i + 1);
      check($sformatf("bp_tag%0d", i), got_tag[i], {i == 0, (i == 3) || (i == 7), i == 7});
    end
    check("bp_outstanding_le2", max_out <= 2, 1);
  endtask

  task automatic t_start_ignore();
    int         roff[$], poff[$], doff[$];
    logic [14:0] raddr[$];
    logic [7:0] pix[$];
    logic       busy12 = 1'b1;
    out_t       cur;
    for (int c = 0; c < 30; c++) begin
      next_cycle();
      start_s = (c == 0) || (c == 3) || (c == 11) || (c == 12);
      ready_s = 1'b1;
      @(negedge clk);
      cur = samp_s();
      if (cur.re) begin raddr.push_back(cur.addr); roff.push_back(c); end
      if (cur.valid) begin pix.push_back(cur.pix); poff.push_back(c); end
      if (cur.done) doff.push_back(c);
      if (c == 12) busy12 = cur.busy;
    end
    start_s = 1'b0;
    check("si_busy_after_done", busy12, 0);
    check("si_read_count", raddr.size(), 16);
    for (int i = 0; i < raddr.size() && i < 16; i++)
      check($sformatf("si_read%0d", i), {raddr[i], 8'(roff[i])}, {15'(i % 8), 8'((i < 8) ? i + 1 : i + 5)});
    check("si_pix_count", pix.size(), 16);
    for (int i = 0; i < pix.size() && i < 16; i++)
      check($sformatf("si_pix%0d", i), {pix[i], 8'(poff[i])}, {8'((i % 8) + 1), 8'((i < 8) ? i + 3 : i + 7)});
    check("si_done_count", doff.size(), 2);
    if (doff.size() == 2) check("si_done_offs", {8'(doff[0]), 8'(doff[1])}, {8'd11, 8'd23});
  endtask

  task automatic t_midreset();
    int   doff[$];
    out_t cur;
    for (int c = 0; c < 25; c++) begin
      next_cycle();
      start_s = (c == 0) || (c == 8);
      rst_n   = (c != 6);
      ready_s = 1'b1;
      @(negedge clk);
      cur = samp_s();
      if (c == 5)  check("mr_pix3", {cur.valid, cur.pix}, {1'b1, 8'd3});
      if (c == 7)  check("mr_after_reset", cur, '0);
      if (c == 9)  check("mr_first_read", {cur.re, cur.addr}, {1'b1, 15'd0});
      if (c == 11) check("mr_sof_pixel", {cur.valid, cur.pix, cur.sof}, {1'b1, 8'd1, 1'b1});
      if (cur.done) doff.push_back(c);
    end
    start_s = 1'b0;
    rst_n   = 1'b1;
    check("mr_done_count", doff.size(), 1);
    if (doff.size() == 1) check("mr_done_off", doff[0], 19);
  endtask

  task automatic t_big();
    int nx = 0, eol_cnt = 0, eol_bad = 0, eof_cnt = 0, eof_pos = -1, pix_bad = 0, sof_bad = 0;
    int done_cnt = 0, done_off = -1, first_valid = -1, last_addr = -1;
    ready_b = 1'b1;
    for (int c = 0; c < 19300; c++) begin
      next_cycle();
      start_b = (c == 0);
      @(negedge clk);
      if (bus_b.o_RAM_Read_Enable) last_addr = int'(bus_b.o_RAM_Adress);
      if (bus_b.o_Pixel_Valid) begin
        if (first_valid < 0) first_valid = c;
        if (bus_b.o_Pixel !== 8'(nx + 1)) pix_bad++;
        if (bus_b.o_EOL) begin eol_cnt++; if ((nx % 160) != 159) eol_bad++; end
        if (bus_b.o_EOF) begin eof_cnt++; eof_pos = nx; end
        if (bus_b.o_SOF != (nx == 0)) sof_bad++;
        nx++;
      end
      if (done_b) begin done_cnt++; done_off = c; end
      if (done_off >= 0 && c > done_off + 2) break;
    end
    check("big_transfers", nx, 19200);
    check("big_last_addr", last_addr, 19199);
    check("big_first_valid", first_valid, 3);
    check("big_pix_bad", pix_bad, 0);
    check("big_sof_bad", sof_bad, 0);
    check("big_eol_cnt", eol_cnt, 120);
    check("big_eol_bad", eol_bad, 0);
    check("big_eof_cnt", eof_cnt, 1);
    check("big_eof_pos", eof_pos, 19199);
    check("big_done_cnt", done_cnt, 1);
    check("big_done_off", done_off, 19203);
  endtask

  initial begin
    t_reset();
    t_table();
    t_backpressure();
    next_cycle();
    @(negedge clk);
    check("bp_idle_after", {busy_s, bus_s.o_Pixel_Valid}, 2'b00);
    t_start_ignore();
    t_midreset();
    t_big();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_ram_reader.md
Name: frame_ram_reader

Overview:
Reads one stored camera frame out of the capture frame RAM and streams it as a pixel sequence, raster order, address 0 upward. Sits on the RAM read port, opposite the camera capture writer, and feeds downstream consumers (display, UART dump, processing) through a valid/ready handshake. Handles the 1-cycle RAM read latency and downstream backpressure without losing or duplicating pixels.

Parameters:
IMG_WIDTH, 160, pixels per line
IMG_HEIGHT, 120, lines per frame
ADDR_W, 15, RAM address width; IMG_WIDTH*IMG_HEIGHT must be <= 2**ADDR_W
DATA_W, 8, pixel/RAM data width

Ports:
i_Clk  in  1  system clock; everything on rising edge
i_Rst_n  in  1  synchronous active-low reset
i_Start  in  1  request one frame readout; sampled only in IDLE
i_RAM_Data  in  DATA_W  RAM read data; valid the cycle after o_RAM_Read_Enable
o_RAM_Adress  out  ADDR_W  RAM read address
o_RAM_Read_Enable  out  1  RAM read strobe, one read per high cycle
o_Pixel  out  DATA_W  output pixel
o_Pixel_Valid  out  1  o_Pixel holds a pixel
i_Pixel_Ready  in  1  consumer accepts; transfer = valid & ready
o_SOF  out  1  qualifies o_Pixel: first pixel of frame
o_EOL  out  1  qualifies o_Pixel: last pixel of a line
o_EOF  out  1  qualifies o_Pixel: last pixel of frame
o_Busy  out  1  high from leaving IDLE until return to IDLE
o_Frame_Done  out  1  one-cycle pulse after the EOF pixel is transferred

Behaviour:
- Reset (i_Rst_n=0 at an edge): state IDLE, all outputs 0, address/x/y counters 0, FIFO and in-flight flag cleared. Applies mid-frame too; discarded pixels are not resumed.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: o_Busy=0. i_Start=1 at edge k -> READ; counters reset to 0. In any other state i_Start is ignored.
- READ: issues a read (o_RAM_Read_Enable=1, o_RAM_Adress=current address) in any cycle where FIFO occupancy + in-flight reads < 2; address increments by 1 per issued read. First read is issued in cycle k+1 with address 0. The read of address IMG_WIDTH*IMG_HEIGHT-1 moves the state to DRAIN. No wrap-around past the last address.
- RAM return: i_RAM_Data from a read in cycle n is pushed into the FIFO at the end of cycle n+1, tagged with SOF (address 0), EOL (x==IMG_WIDTH-1), and EOF (final address). x wraps to 0 and y increments at end of line.
- Output FIFO: 2 entries (skid). o_Pixel_Valid=1 whenever not empty; o_Pixel and tags come from the head entry. While valid & !ready, o_Pixel and tags hold stable. Push and pop in the same cycle are allowed. The credit rule makes overflow impossible.
- Latency: first o_Pixel_Valid in cycle k+3. With ready held high, throughput is 1 pixel/cycle and the frame's last transfer occurs in cycle k+2+W*H.
- DRAIN: no reads issued; goes to DONE when the EOF pixel is transferred.
- DONE: o_Frame_Done=1 for exactly one cycle, o_Busy still 1; then IDLE. A new i_Start is accepted from the next cycle.
- o_RAM_Read_Enable is 0 outside READ. o_RAM_Adress holds its last value when not reading.
- Counters sized to ADDR_W, clog2(IMG_WIDTH), and clog2(IMG_HEIGHT). All arithmetic is unsigned; no intermediate truncation.

Decomposition:
- Shared camera package: IMG_WIDTH/IMG_HEIGHT defaults, ADDR_W, DATA_W, FRAME_PIXELS constant, so capture writer and reader agree on geometry.
- State encoding localparams stay local.
- One sub-module: pixel_skid_fifo (2-entry, DATA_W+3 bits wide: pixel + SOF/EOL/EOF), with push/pop/full/empty/count outputs.

Test Plan:
- Reset: hold i_Rst_n=0 for 3 cycles with i_Start=1 -> all outputs 0, no read strobes.
- Frame, W=4 H=2, RAM model data=addr+1, ready=1 -> reads addr 0..7 in cycles k+1..k+8; pixels 1..8 in cycles k+3..k+10; SOF on 1, EOL on 4 and 8, EOF on 8; o_Frame_Done one pulse in k+11; o_Busy high k+1..k+11.
- Backpressure, W=4 H=2: ready=0 for 5 cycles after pixel 2, then alternating 1/0 -> output sequence exactly 1..8 with no gaps or duplicates; o_Pixel stable while stalled; never more than 2 reads outstanding/buffered.
- i_Start pulsed during READ and during DONE -> ignored; exactly one frame emitted; a start in the cycle after DONE begins a new frame at address 0.
- Reset mid-frame: i_Rst_n=0 after the pixel-3 transfer -> next cycle all outputs 0, state IDLE; a subsequent i_Start yields SOF pixel = data of address 0.
- Defaults 160x120, ready=1 -> 19200 transfers, last address 19199, EOL every 160th pixel, single EOF, o_Frame_Done once.
